// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared constants for the Sobel 3x3 window generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int SOBEL_DWIDTH = 8;
    localparam int WIN_ROWS     = 3;
    localparam int WIN_COLS     = 3;
    localparam int WIN_TAPS     = WIN_ROWS * WIN_COLS;

    // Tap k = row*3 + col, row 0 = top, col 0 = left
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

    localparam int         STATE_W = 2;
    localparam logic [1:0] FILL    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] FLUSH   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_line_buffer
// Description : One-row circular buffer; read-before-write at a shared pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter  int DWIDTH = SOBEL_DWIDTH,
    parameter  int DEPTH  = 720,
    localparam int AWIDTH = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              i_en,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Read returns the entry written one full row ago at this pointer
    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_gen
// Description : Raster grayscale stream to padded 3x3 windows, one per pixel.
//               SOBEL_WINDOW_REPLICATE_EN selects edge replicate over zero pad.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter  int DWIDTH     = SOBEL_DWIDTH,
    parameter  int IMG_WIDTH  = 720,
    parameter  int IMG_HEIGHT = 540,
    localparam int WIN_DWIDTH = WIN_TAPS * DWIDTH
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DWIDTH-1:0]     in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [WIN_DWIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  frame_done
);

    localparam int              c_CW       = $clog2(IMG_WIDTH);
    localparam int              c_RW       = $clog2(IMG_HEIGHT);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_HEIGHT - 1);
    localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);

    logic [STATE_W-1:0]               r_state;
    logic [STATE_W-1:0]               w_state_nxt;
    logic                             w_adv;
    logic                             w_consume;
    logic                             w_emit;
    logic                             w_wr_en;
    logic                             w_stage_free;
    logic                             w_last_emit;
    logic [c_CW-1:0]                  r_col;
    logic [c_RW-1:0]                  r_row;
    logic [c_CW-1:0]                  r_ecol;
    logic [c_RW-1:0]                  r_erow;
    logic [DWIDTH-1:0]                w_pix;
    logic [DWIDTH-1:0]                w_lb1_rd;
    logic [DWIDTH-1:0]                w_lb2_rd;
    logic [WIN_TAPS-1:0][DWIDTH-1:0]  r_win;
    logic [WIN_TAPS-1:0][DWIDTH-1:0]  w_win_nxt;
    logic [WIN_TAPS-1:0][DWIDTH-1:0]  w_win_out;
    logic                             w_top;
    logic                             w_bot;
    logic                             w_left;
    logic                             w_right;
    logic                             r_out_valid;
    logic                             r_out_last;
    logic                             r_frame_done;
    logic [WIN_DWIDTH-1:0]            r_out_din;

    assign w_wr_en      = r_out_valid & ~out_full;
    assign w_stage_free = ~r_out_valid | w_wr_en;
    assign w_consume    = w_adv & (r_state != FLUSH);
    assign w_emit       = w_adv & (r_state != FILL);
    assign w_pix        = (r_state == FLUSH) ? '0 : in_dout;
    assign w_last_emit  = (r_erow == c_ROW_LAST) && (r_ecol == c_COL_LAST);

    assign in_rd_en   = w_consume;
    assign out_wr_en  = w_wr_en;
    assign out_din    = r_out_din;
    assign frame_done = r_frame_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            FILL: begin
                w_adv = ~in_empty;
                if (w_adv && (r_row == c_ROW_ONE) && (r_col == '0)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_adv = ~in_empty & w_stage_free;
                if (w_adv && (r_row == c_ROW_LAST) && (r_col == c_COL_LAST)) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_adv = w_stage_free;
                if (w_adv && w_last_emit) begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // Input pointer (col/row) and centre position of the window being emitted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_ecol <= '0;
            r_erow <= '0;
        end else if (w_adv) begin
            if ((r_state == FLUSH) && w_last_emit) begin
                r_col  <= '0;
                r_row  <= '0;
                r_ecol <= '0;
                r_erow <= '0;
            end else begin
                r_col <= (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;
                if ((r_col == c_COL_LAST) && (r_row != c_ROW_LAST)) begin
                    r_row <= r_row + 1'b1;
                end
                if (w_emit) begin
                    r_ecol <= (r_ecol == c_COL_LAST) ? '0 : r_ecol + 1'b1;
                    if ((r_ecol == c_COL_LAST) && (r_erow != c_ROW_LAST)) begin
                        r_erow <= r_erow + 1'b1;
                    end
                end
            end
        end
    end

    sobel_line_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (IMG_WIDTH)
    ) u_lb1 (
        .clk       (clock),
        .i_en      (w_adv),
        .i_addr    (r_col),
        .i_wr_data (w_pix),
        .o_rd_data (w_lb1_rd)
    );

    sobel_line_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (IMG_WIDTH)
    ) u_lb2 (
        .clk       (clock),
        .i_en      (w_adv),
        .i_addr    (r_col),
        .i_wr_data (w_lb1_rd),
        .o_rd_data (w_lb2_rd)
    );

    generate
        for (genvar gr = 0; gr < WIN_ROWS; gr++) begin : g_shift
            assign w_win_nxt[gr*WIN_COLS + 0] = r_win[gr*WIN_COLS + 1];
            assign w_win_nxt[gr*WIN_COLS + 1] = r_win[gr*WIN_COLS + 2];
        end
    endgenerate

    assign w_win_nxt[TAP_TR] = w_lb2_rd;
    assign w_win_nxt[TAP_MR] = w_lb1_rd;
    assign w_win_nxt[TAP_BR] = w_pix;

    assign w_top   = (r_erow == '0);
    assign w_bot   = (r_erow == c_ROW_LAST);
    assign w_left  = (r_ecol == '0);
    assign w_right = (r_ecol == c_COL_LAST);

    generate
        for (genvar gk = 0; gk < WIN_TAPS; gk++) begin : g_tap
            localparam int c_ROW = gk / WIN_COLS;
            localparam int c_COL = gk % WIN_COLS;
            logic w_mrow;
            logic w_mcol;
            assign w_mrow = ((c_ROW == 0) && w_top) || ((c_ROW == WIN_ROWS - 1) && w_bot);
            assign w_mcol = ((c_COL == 0) && w_left) || ((c_COL == WIN_COLS - 1) && w_right);
`ifdef SOBEL_WINDOW_REPLICATE_EN
            // Masked row/column falls back to the centre row/column
            logic [3:0] w_src;
            assign w_src = 4'((w_mrow ? 1 : c_ROW) * WIN_COLS + (w_mcol ? 1 : c_COL));
            assign w_win_out[gk] = w_win_nxt[w_src];
`else
            assign w_win_out[gk] = (w_mrow || w_mcol) ? '0 : w_win_nxt[gk];
`endif
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_win        <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_din    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wr_en & r_out_last;
            if (w_adv) begin
                r_win <= w_win_nxt;
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_emit;
                r_out_din   <= w_win_out;
            end else if (w_wr_en) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_gen
// Description : Directed bench for sobel_window_gen on a 4x3 image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int WDW  = 9 * DW;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [DW-1:0]  in_dout;
    logic           in_empty;
    logic           in_rd_en;
    logic [WDW-1:0] out_din;
    logic           out_full;
    logic           out_wr_en;
    logic           frame_done;

    always #5 clock = ~clock;

    sobel_window_gen #(
        .DWIDTH     (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_dout    (in_dout),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .out_din    (out_din),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .frame_done (frame_done)
    );

    int             n_checks = 0;
    int             n_errors = 0;
    int             push_cnt = 0;
    int             fd_cnt   = 0;
    bit             fd_exp   = 1'b0;
    logic [WDW-1:0] got [NPIX];
    logic [DW-1:0]  src_q [$];

    function automatic logic [WDW-1:0] pack9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
        int t [9];
        logic [WDW-1:0] p;
        t = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
        p = '0;
        for (int k = 0; k < 9; k++) p[DW*k +: DW] = DW'(t[k]);
        return p;
    endfunction

    // Pixel (r,c) of the test image holds r*W+c+1; out-of-image taps per pad mode
    function automatic logic [WDW-1:0] model_win(input int idx);
        logic [WDW-1:0] w;
        int r, c, rr, cc, v;
        w = '0;
        r = idx / W;
        c = idx % W;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
`ifdef SOBEL_WINDOW_REPLICATE_EN
                rr = (rr < 0) ? 0 : ((rr >= H) ? H - 1 : rr);
                cc = (cc < 0) ? 0 : ((cc >= W) ? W - 1 : cc);
                v  = rr * W + cc + 1;
`else
                v  = ((rr >= 0) && (rr < H) && (cc >= 0) && (cc < W)) ? rr * W + cc + 1 : 0;
`endif
                w[DW*((dr + 1) * 3 + (dc + 1)) +: DW] = DW'(v);
            end
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [WDW-1:0] act, input logic [WDW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard step, called once per cycle at the falling edge
    task automatic sb_cycle();
        int idx;
        check("frame_done", {71'd0, frame_done}, {71'd0, fd_exp});
        if (frame_done) fd_cnt++;
        fd_exp = 1'b0;
        check("rd_while_empty", {71'd0, in_rd_en & in_empty}, '0);
        if (!reset) begin
            push_cnt = 0;
            fd_cnt   = 0;
        end else if (out_wr_en) begin
            idx = push_cnt % NPIX;
            check($sformatf("window%0d", idx), out_din, model_win(idx));
            got[idx] = out_din;
            fd_exp   = (idx == NPIX - 1);
            push_cnt++;
        end
    endtask

    task automatic do_reset();
        in_empty = 1'b1;
        in_dout  = '0;
        out_full = 1'b0;
        reset    = 1'b0;
        repeat (3) begin
            @(negedge clock);
            sb_cycle();
            check("rst_out_din", out_din, '0);
            check("rst_wr_en", {71'd0, out_wr_en}, '0);
            check("rst_rd_en", {71'd0, in_rd_en}, '0);
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        src_q.delete();
    endtask

    task automatic run_frame(input bit starve, input bit bp, input int stop_px,
                             input int nframes, output int cycles);
        int             cyc      = 0;
        int             popped   = 0;
        int             bp_left  = 0;
        int             bp_seen  = 0;
        int             start_p  = push_cnt;
        int             start_fd = fd_cnt;
        bit             bp_done  = 1'b0;
        bit             rd;
        bit             empty_s;
        logic [WDW-1:0] held     = '0;
        for (int f = 0; f < nframes; f++)
            for (int i = 1; i <= NPIX; i++) src_q.push_back(DW'(i));
        while (1) begin
            if ((stop_px > 0) && (popped >= stop_px)) break;
            if ((push_cnt - start_p == nframes * NPIX) && (fd_cnt - start_fd == nframes)
                && (src_q.size() == 0)) break;
            if (cyc >= 400) begin
                n_checks++;
                n_errors++;
                $display("FAIL timeout: pushes %0d frames %0d expected %0d/%0d",
                         push_cnt - start_p, fd_cnt - start_fd, nframes * NPIX, nframes);
                break;
            end
            in_empty = (src_q.size() == 0) || (starve && (cyc % 2 == 1));
            in_dout  = (src_q.size() != 0) ? src_q[0] : '0;
            if (bp && !bp_done && (push_cnt - start_p == 4)) begin
                bp_left = 5;
                bp_done = 1'b1;
            end
            out_full = (bp_left > 0);
            @(negedge clock);
            sb_cycle();
            rd      = in_rd_en;
            empty_s = in_empty;
            if (out_full) begin
                check("bp_wr_en", {71'd0, out_wr_en}, '0);
                check("bp_rd_en", {71'd0, in_rd_en}, '0);
                if (bp_seen > 0) check("bp_hold", out_din, held);
                else held = out_din;
                bp_seen++;
            end
            @(posedge clock);
            #1;
            if (rd && !empty_s) begin
                void'(src_q.pop_front());
                popped++;
            end
            if (bp_left > 0) bp_left--;
            cyc++;
        end
        out_full = 1'b0;
        in_empty = 1'b1;
        cycles   = cyc;
        if (stop_px == 0) begin
            repeat (3) begin
                @(negedge clock);
                sb_cycle();
                @(posedge clock);
                #1;
            end
            check("push_count", WDW'(push_cnt - start_p), WDW'(nframes * NPIX));
            check("frame_done_count", WDW'(fd_cnt - start_fd), WDW'(nframes));
            if (bp) check("bp_cycles", WDW'(bp_seen), WDW'(5));
        end
    endtask

    logic [WDW-1:0] lit_w0, lit_w5, lit_w11;
    int             cycles;

    initial begin
        in_dout  = '0;
        in_empty = 1'b1;
        out_full = 1'b0;
`ifdef SOBEL_WINDOW_REPLICATE_EN
        lit_w0  = pack9(1, 1, 2, 1, 1, 2, 5, 5, 6);
        lit_w11 = pack9(7, 8, 8, 11, 12, 12, 11, 12, 12);
`else
        lit_w0  = pack9(0, 0, 0, 0, 1, 2, 0, 5, 6);
        lit_w11 = pack9(7, 8, 0, 11, 12, 0, 0, 0, 0);
`endif
        lit_w5  = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);

        check("model_w0", model_win(0), lit_w0);
        check("model_w5", model_win(5), lit_w5);
        check("model_w11", model_win(11), lit_w11);

        do_reset();
        run_frame(1'b0, 1'b0, 0, 1, cycles);
        check("basic_w0", got[0], lit_w0);
        check("basic_w5", got[5], lit_w5);
        check("basic_w11", got[11], lit_w11);

        do_reset();
        run_frame(1'b0, 1'b1, 0, 1, cycles);

        do_reset();
        run_frame(1'b1, 1'b0, 0, 1, cycles);
        check("starve_w11", got[11], lit_w11);

        do_reset();
        run_frame(1'b0, 1'b0, 7, 1, cycles);
        do_reset();
        run_frame(1'b0, 1'b0, 0, 1, cycles);
        check("rst_w0", got[0], lit_w0);
        check("rst_w5", got[5], lit_w5);
        check("rst_w11", got[11], lit_w11);

        do_reset();
        run_frame(1'b0, 1'b0, 0, 2, cycles);
        check("b2b_cycles_le", WDW'(cycles <= 2 * (NPIX + W + 1) + 4), WDW'(1));
        check("b2b_w11", got[11], lit_w11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Parametrised successor to the fixed three-row Sobel feed. The feed currently needs three pre-offset RGB rows per cycle and wraps around at image edges.
- This block reads a single raster-order grayscale pixel stream from a show-ahead FIFO, holds two line buffers internally, and emits one full 3x3 window per image pixel to the Sobel FIFO.
- Image borders are padded, so exactly IMG_WIDTH*IMG_HEIGHT windows are emitted per frame.
- Sits between the grayscale stage and the Sobel stage in dut_system.

Parameters:
- DWIDTH, 8, bits per grayscale pixel.
- IMG_WIDTH, 720, pixels per row (>=2).
- IMG_HEIGHT, 540, rows per frame (>=2).
- WIN_DWIDTH, 9*DWIDTH, derived localparam: window word width.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_dout  in  DWIDTH  upstream show-ahead FIFO data, valid while in_empty=0.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pop upstream FIFO (combinational).
- out_din  out  WIN_DWIDTH  window word; tap k=row*3+col (row 0 = top, col 0 = left) at bits [DWIDTH*(k+1)-1 : DWIDTH*k]. Centre pixel is k=4.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  push downstream FIFO (combinational).
- frame_done  out  1  one-cycle pulse, registered, the cycle after the last window of a frame is pushed.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FILL; col/row/emit counters=0; out_valid=0; out_din=0; frame_done=0.
  - Line buffer contents are don't-care.
- Output stage:
  - Register out_din plus internal out_valid.
  - out_wr_en = out_valid & ~out_full.
  - stage_free = ~out_valid | out_wr_en.
- Advance rules:
  - FILL advances when ~in_empty.
  - RUN advances when ~in_empty & stage_free.
  - FLUSH advances when stage_free.
- in_rd_en = advance & state!=FLUSH.
- On a consuming advance:
  - The pixel shifts into the 3x3 window and line buffers.
  - The input counter increments.
- States:
  - FILL: consume pixels 0..IMG_WIDTH; no output. Move to RUN after pixel index IMG_WIDTH is consumed.
  - RUN:
    - Each advance consumes pixel n and loads the window centred at n-(IMG_WIDTH+1) into the output stage; out_valid=1.
    - After pixel IMG_WIDTH*IMG_HEIGHT-1, go to FLUSH.
  - FLUSH:
    - Each advance shifts in a dummy 0 and emits the next window.
    - After IMG_WIDTH+1 flush windows, return to FILL with counters cleared.
- Latency:
  - First window is registered one cycle after pixel IMG_WIDTH+1 is consumed.
  - At full rate, one window per cycle.
- Borders (centre at row r, col c):
  - r=0: masks taps 0-2.
  - r=IMG_HEIGHT-1: masks taps 6-8.
  - c=0: masks taps 0,3,6.
  - c=IMG_WIDTH-1: masks taps 2,5,8.
  - Masked taps are 0 (default mode).
  - Corners apply both masks. No wrap-around data ever appears in a window.
- Line buffers: two IMG_WIDTH-deep circular RAMs sharing one column pointer, which wraps at IMG_WIDTH-1.
- Simultaneous events:
  - A push and a reload of the output stage in the same cycle is legal.
  - in_empty during RUN stalls the stage; out_valid holds its current word until it is pushed.
- frame_done: asserted the cycle after the IMG_WIDTH*IMG_HEIGHT-th out_wr_en of a frame.
- Back-to-back frames: the FILL for frame N+1 may begin while the last window of frame N is still in the output stage.
- Reset mid-frame: all counters and the FSM return to FILL; any partially held window is discarded.

Optional Feature:
- Macro: SOBEL_WINDOW_REPLICATE_EN.
- Defined: masked taps take the nearest in-image pixel (edge replicate).
  - Row mask copies the centre row.
  - Column mask copies the centre column.
  - Corners copy the centre pixel.
- Undefined: masked taps are 0.
- Counters, latency and handshakes are identical in both modes.

Decomposition:
- Shared package sobel_pkg holds:
  - DWIDTH and window-size constants.
  - Tap index constants TAP_TL..TAP_BR (0..8).
  - FSM state encoding FILL/RUN/FLUSH.
- Sub-module sobel_line_buffer: single-port-read/write circular buffer of depth IMG_WIDTH, instantiated twice and chained.

Test Plan:
- Zero-pad, W=4, H=3, pixels 1..12, out_full=0:
  - Exactly 12 pushes.
  - Window 0 = {0,0,0, 0,1,2, 0,5,6}.
  - Window 5 = {1,2,3, 5,6,7, 9,10,11}.
  - Window 11 = {7,8,0, 11,12,0, 0,0,0}.
  - frame_done pulses once, the cycle after the 12th push.
- SOBEL_WINDOW_REPLICATE_EN, same stimulus:
  - Window 0 = {1,1,2, 1,1,2, 5,5,6}.
  - Window 11 = {7,8,8, 11,12,12, 11,12,12}.
- Backpressure: hold out_full=1 for 5 cycles mid-RUN.
  - out_wr_en=0 and in_rd_en=0 throughout.
  - out_din stable.
  - All 12 windows delivered in order, none lost or duplicated.
- Input starvation: in_empty=1 on every other cycle.
  - Window sequence identical to the first scenario.
  - No push occurs while the stage is empty.
- Reset mid-frame: assert reset after pixel 7, then feed a fresh frame 1..12.
  - All outputs are 0 during reset.
  - Output matches the first scenario exactly.
- Full-size W=720, H=540, two back-to-back frames:
  - 388800 pushes per frame.
  - frame_done pulses twice.
  - Total cycles ≈ 2*388800 + 2*721 + small constant, with no stalls.
